inter_ref_req_gen: RTL and testbench
====================================

// Module: inter_ref_req_gen
// PURPOSE
//  Upstream neighbour of the inter reference-pixel cache. Accepts one prediction-unit (PU) request per handshake:
//  position, size, quarter-pel MV and ref_idx. Tiles the PU into <=8x8 luma sub-blocks and issues one
//  cache request per sub-block. Each request carries luma/chroma reference-window start, window size and
//  chroma fractional phase, already expanded for the 8-tap luma / 4-tap chroma interpolation margin.
// PARAMETERS
//  MVD_WIDTH        16  signed quarter-pel MV width
//  MV_L_FRAC_W      2   luma MV fractional bits; integer part width MV_INT_W = MVD_WIDTH-MV_L_FRAC_W
//  MV_C_FRAC_W      3   chroma fractional bits (4:2:0, eighth-pel)
//  PIC_COORD_W      12  unsigned PU x/y coordinate width
//  PU_DIM_W         7   PU width/height field width (values 4..64, multiple of 4)
//  LUMA_DIM_WDTH    4   ref-window size field width (max 15)
//  REF_ADDR_WDTH    4   ref_idx width
// PORTS
//  clk                          in   1            clock
//  reset                        in   1            synchronous, active-low
//  pu_valid / pu_ready          in/out 1          PU request handshake
//  pu_x / pu_y                  in   PIC_COORD_W  PU top-left luma sample
//  pu_w / pu_h                  in   PU_DIM_W     PU size in luma samples
//  mv_x / mv_y                  in   MVD_WIDTH    L0 MV, signed quarter-pel
//  ref_idx                      in   REF_ADDR_WDTH L0 reference index
//  valid_in                     out  1            request valid to cache
//  cache_idle_out               in   1            cache ready; transfer = valid_in & cache_idle_out
//  ref_idx_in_in                out  REF_ADDR_WDTH reference index for request
//  luma_ref_start_x_in / _y_in  out  MV_INT_W     signed luma window start
//  luma_ref_width_x_in / height_y_in out LUMA_DIM_WDTH luma window size
//  chma_ref_start_x_in / _y_in  out  MV_INT_W     signed chroma window start
//  chma_ref_width_x_in / height_y_in out LUMA_DIM_WDTH chroma window size
//  ch_frac_x / ch_frac_y        out  MV_C_FRAC_W  chroma fractional phase
//  req_last                     out  1            final request of current PU
// BEHAVIOUR
//  - Reset (reset==0): state IDLE, all outputs 0, pu_ready 0. pu_ready = (state==IDLE) once reset==1.
//  - Reset mid-PU: the in-flight PU is discarded with no further requests; restart from IDLE.
//  - FSM IDLE: pu_valid&pu_ready captures the PU. sub_x = sub_y = 0. Go to ISSUE.
//    First request has valid_in=1 in the next cycle: latency 1.
//  - FSM ISSUE: valid_in held high and all request fields stable until cache_idle_out==1.
//    On transfer: if more sub-blocks remain, load the next sub-block's fields in the same edge (1 request/cycle max).
//    Otherwise go to IDLE with valid_in=0.
//  - Tiling order: raster order, x-major. sub_w = min(8, pu_w-sub_x) and sub_h = min(8, pu_h-sub_y).
//    req_last=1 only on the last sub-block.
//  - Luma arithmetic: int = mv >>> 2 (arithmetic), frac = mv[1:0].
//    start = pu+sub+int-3. width = sub_w+7, height = sub_h+7. The margin is always applied, whatever frac.
//  - Chroma arithmetic: cint = mv >>> 3, ch_frac = mv[2:0].
//    start = ((pu+sub)>>1)+cint-1. width = sub_w/2+3, height = sub_h/2+3.
//  - All coordinates are signed MV_INT_W two's-complement and wrap on overflow with no saturation.
//    Negative and out-of-picture windows pass through unchanged; the cache clamps them.
//  - pu_w/pu_h not a multiple of 4, or outside 4..64: undefined; assertion only.
// CONFIGURATION
//  REQ_GEN_BIPRED_EN defined:
//  - Adds ports mv1_x, mv1_y (in, MVD_WIDTH), ref_idx1 (in, REF_ADDR_WDTH), pred_flag (in, 2), req_list (out, 1).
//  - Each sub-block issues an L0 request, then an L1 request, only for lists set in pred_flag.
//  - req_list identifies the list. req_last is set on the final list of the final sub-block.
//  - pred_flag==0 is accepted and consumed, with no requests issued.
//  REQ_GEN_BIPRED_EN undefined: L0 only, none of those ports exist.
// STRUCTURE
//  - Package inter_req_pkg holds:
//    - typedefs pu_req_t, cache_req_t;
//    - constants LUMA_TAP_MARGIN=3, CHMA_TAP_MARGIN=1, SUB_BLK=8;
//    - enum req_state_e {IDLE, ISSUE}.
//  - Sub-module inter_ref_coord_calc: combinational. Inputs (pu pos, sub offset, sub size, mv); output cache_req_t.
//    The top holds the FSM, sub-block counters, list counter and output registers.
// TESTING
//  1. PU (16,8) 8x8, mv(0,0), ref 0 -> one request: luma start (13,5) 15x15; chroma (7,3) 7x7; frac (0,0); req_last=1.
//  2. PU (0,0) 16x8, mv(-5,6) -> two requests.
//     Req 1: luma (-5,-2), chroma (-2,-1), frac (3,6).
//     Req 2: luma (3,-2), chroma (2,-1), frac (3,6), req_last=1.
//  3. Case 1 with cache_idle_out low for 5 cycles -> valid_in held 6 cycles, fields stable, exactly one transfer.
//  4. PU (0,0) 12x4, mv 0 -> requests are luma 15x11 then 11x11, and chroma 7x5 then 5x5.
//  5. PU 64x64 with reset low after 3 transfers -> next cycle all outputs 0.
//     A new 8x8 PU then issues one correct request.
//  6. BIPRED_EN, PU 16x8, pred_flag=3 -> 4 requests, req_list 0,1,0,1, ref_idx/ref_idx1 alternating.

Source files
------------

// File: rtl/inter_req_pkg.sv
// Shared types and constants for the inter reference-pixel request generator.
// Optional bi-prediction support is enabled with the REQ_GEN_BIPRED_EN macro.
package inter_req_pkg;

  localparam int MVD_WIDTH     = 16;
  localparam int MV_L_FRAC_W   = 2;
  localparam int MV_C_FRAC_W   = 3;
  localparam int MV_INT_W      = MVD_WIDTH - MV_L_FRAC_W;
  localparam int PIC_COORD_W   = 12;
  localparam int PU_DIM_W      = 7;
  localparam int LUMA_DIM_WDTH = 4;
  localparam int REF_ADDR_WDTH = 4;

  localparam int LUMA_TAP_MARGIN = 3;
  localparam int CHMA_TAP_MARGIN = 1;
  localparam int SUB_BLK         = 8;

  typedef enum logic [0:0] {IDLE, ISSUE} req_state_e;

  typedef struct packed {
    logic [PIC_COORD_W-1:0]      x;
    logic [PIC_COORD_W-1:0]      y;
    logic [PU_DIM_W-1:0]         w;
    logic [PU_DIM_W-1:0]         h;
    logic signed [MVD_WIDTH-1:0] mv_x;
    logic signed [MVD_WIDTH-1:0] mv_y;
    logic [REF_ADDR_WDTH-1:0]    ref_idx;
    logic signed [MVD_WIDTH-1:0] mv1_x;
    logic signed [MVD_WIDTH-1:0] mv1_y;
    logic [REF_ADDR_WDTH-1:0]    ref_idx1;
    logic [1:0]                  pred_flag;
  } pu_req_t;

  typedef struct packed {
    logic signed [MV_INT_W-1:0] luma_x;
    logic signed [MV_INT_W-1:0] luma_y;
    logic [LUMA_DIM_WDTH-1:0]   luma_w;
    logic [LUMA_DIM_WDTH-1:0]   luma_h;
    logic signed [MV_INT_W-1:0] chma_x;
    logic signed [MV_INT_W-1:0] chma_y;
    logic [LUMA_DIM_WDTH-1:0]   chma_w;
    logic [LUMA_DIM_WDTH-1:0]   chma_h;
    logic [MV_C_FRAC_W-1:0]     frac_x;
    logic [MV_C_FRAC_W-1:0]     frac_y;
  } cache_req_t;

  // Size of the sub-block starting at offset off inside a PU dimension of total.
  function automatic logic [PU_DIM_W-1:0] sub_dim(input logic [PU_DIM_W-1:0] total,
                                                  input logic [PU_DIM_W-1:0] off);
    logic [PU_DIM_W-1:0] rem;
    rem = total - off;
    return (rem > PU_DIM_W'(SUB_BLK)) ? PU_DIM_W'(SUB_BLK) : rem;
  endfunction

endpackage

// File: rtl/inter_ref_coord_calc.sv
// Combinational reference-window calculator for one luma sub-block and its chroma
// counterpart, including the interpolation filter margins.
module inter_ref_coord_calc
  import inter_req_pkg::*;
(
  input  logic [PIC_COORD_W-1:0]      i_pu_x,
  input  logic [PIC_COORD_W-1:0]      i_pu_y,
  input  logic [PU_DIM_W-1:0]         i_sub_x,
  input  logic [PU_DIM_W-1:0]         i_sub_y,
  input  logic [PU_DIM_W-1:0]         i_sub_w,
  input  logic [PU_DIM_W-1:0]         i_sub_h,
  input  logic signed [MVD_WIDTH-1:0] i_mv_x,
  input  logic signed [MVD_WIDTH-1:0] i_mv_y,
  output cache_req_t                  o_req
);

  localparam int LumaExt = 2 * LUMA_TAP_MARGIN + 1;
  localparam int ChmaExt = 2 * CHMA_TAP_MARGIN + 1;

  logic [MV_INT_W-1:0] w_pos_x;
  logic [MV_INT_W-1:0] w_pos_y;
  logic [MV_INT_W-1:0] w_lint_x;
  logic [MV_INT_W-1:0] w_lint_y;
  logic [MV_INT_W-1:0] w_cint_x;
  logic [MV_INT_W-1:0] w_cint_y;

  assign w_pos_x  = MV_INT_W'(i_pu_x) + MV_INT_W'(i_sub_x);
  assign w_pos_y  = MV_INT_W'(i_pu_y) + MV_INT_W'(i_sub_y);
  assign w_lint_x = MV_INT_W'(i_mv_x >>> MV_L_FRAC_W);
  assign w_lint_y = MV_INT_W'(i_mv_y >>> MV_L_FRAC_W);
  assign w_cint_x = MV_INT_W'(i_mv_x >>> MV_C_FRAC_W);
  assign w_cint_y = MV_INT_W'(i_mv_y >>> MV_C_FRAC_W);

  // Plain modular arithmetic: out-of-picture windows are clamped by the cache.
  always_comb begin
    o_req        = '0;
    o_req.luma_x = w_pos_x + w_lint_x - MV_INT_W'(LUMA_TAP_MARGIN);
    o_req.luma_y = w_pos_y + w_lint_y - MV_INT_W'(LUMA_TAP_MARGIN);
    o_req.luma_w = LUMA_DIM_WDTH'(i_sub_w + PU_DIM_W'(LumaExt));
    o_req.luma_h = LUMA_DIM_WDTH'(i_sub_h + PU_DIM_W'(LumaExt));
    o_req.chma_x = (w_pos_x >> 1) + w_cint_x - MV_INT_W'(CHMA_TAP_MARGIN);
    o_req.chma_y = (w_pos_y >> 1) + w_cint_y - MV_INT_W'(CHMA_TAP_MARGIN);
    o_req.chma_w = LUMA_DIM_WDTH'((i_sub_w >> 1) + PU_DIM_W'(ChmaExt));
    o_req.chma_h = LUMA_DIM_WDTH'((i_sub_h >> 1) + PU_DIM_W'(ChmaExt));
    o_req.frac_x = i_mv_x[MV_C_FRAC_W-1:0];
    o_req.frac_y = i_mv_y[MV_C_FRAC_W-1:0];
  end

endmodule

// File: rtl/inter_ref_req_gen.sv
// Tiles each PU into <=8x8 sub-blocks and issues one reference-window request per
// sub-block (and per list when REQ_GEN_BIPRED_EN is defined) to the reference cache.
module inter_ref_req_gen
  import inter_req_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pu_valid,
  output logic                        pu_ready,
  input  logic [PIC_COORD_W-1:0]      pu_x,
  input  logic [PIC_COORD_W-1:0]      pu_y,
  input  logic [PU_DIM_W-1:0]         pu_w,
  input  logic [PU_DIM_W-1:0]         pu_h,
  input  logic signed [MVD_WIDTH-1:0] mv_x,
  input  logic signed [MVD_WIDTH-1:0] mv_y,
  input  logic [REF_ADDR_WDTH-1:0]    ref_idx,
`ifdef REQ_GEN_BIPRED_EN
  input  logic signed [MVD_WIDTH-1:0] mv1_x,
  input  logic signed [MVD_WIDTH-1:0] mv1_y,
  input  logic [REF_ADDR_WDTH-1:0]    ref_idx1,
  input  logic [1:0]                  pred_flag,
  output logic                        req_list,
`endif
  output logic                        valid_in,
  input  logic                        cache_idle_out,
  output logic [REF_ADDR_WDTH-1:0]    ref_idx_in_in,
  output logic signed [MV_INT_W-1:0]  luma_ref_start_x_in,
  output logic signed [MV_INT_W-1:0]  luma_ref_start_y_in,
  output logic [LUMA_DIM_WDTH-1:0]    luma_ref_width_x_in,
  output logic [LUMA_DIM_WDTH-1:0]    luma_ref_height_y_in,
  output logic signed [MV_INT_W-1:0]  chma_ref_start_x_in,
  output logic signed [MV_INT_W-1:0]  chma_ref_start_y_in,
  output logic [LUMA_DIM_WDTH-1:0]    chma_ref_width_x_in,
  output logic [LUMA_DIM_WDTH-1:0]    chma_ref_height_y_in,
  output logic [MV_C_FRAC_W-1:0]      ch_frac_x,
  output logic [MV_C_FRAC_W-1:0]      ch_frac_y,
  output logic                        req_last
);

  localparam logic [PU_DIM_W-1:0] SubStep = PU_DIM_W'(SUB_BLK);

  req_state_e               r_state;
  pu_req_t                  r_pu;
  logic [PU_DIM_W-1:0]      r_sub_x;
  logic [PU_DIM_W-1:0]      r_sub_y;
  logic                     r_list;
  logic                     r_valid;
  cache_req_t               r_req;
  logic [REF_ADDR_WDTH-1:0] r_ref;
  logic                     r_last;

  pu_req_t                     w_in_pu;
  pu_req_t                     w_src;
  logic [PU_DIM_W-1:0]         w_sub_x;
  logic [PU_DIM_W-1:0]         w_sub_y;
  logic [PU_DIM_W-1:0]         w_sub_w;
  logic [PU_DIM_W-1:0]         w_sub_h;
  logic                        w_list;
  logic                        w_last;
  logic                        w_done;
  logic                        w_load;
  logic signed [MVD_WIDTH-1:0] w_mv_x;
  logic signed [MVD_WIDTH-1:0] w_mv_y;
  logic [REF_ADDR_WDTH-1:0]    w_ref;
  cache_req_t                  w_calc;

  always_comb begin
    w_in_pu         = '0;
    w_in_pu.x       = pu_x;
    w_in_pu.y       = pu_y;
    w_in_pu.w       = pu_w;
    w_in_pu.h       = pu_h;
    w_in_pu.mv_x    = mv_x;
    w_in_pu.mv_y    = mv_y;
    w_in_pu.ref_idx = ref_idx;
`ifdef REQ_GEN_BIPRED_EN
    w_in_pu.mv1_x     = mv1_x;
    w_in_pu.mv1_y     = mv1_y;
    w_in_pu.ref_idx1  = ref_idx1;
    w_in_pu.pred_flag = pred_flag;
`else
    w_in_pu.pred_flag = 2'b01;
`endif
  end

  // Next request: first sub-block of the incoming PU in IDLE, successor of the current one in ISSUE.
  always_comb begin
    w_src   = (r_state == ISSUE) ? r_pu : w_in_pu;
    w_sub_x = '0;
    w_sub_y = '0;
    w_list  = ~w_src.pred_flag[0];
    w_done  = 1'b0;
    if (r_state == ISSUE) begin
      if (!r_list && r_pu.pred_flag[1]) begin
        w_sub_x = r_sub_x;
        w_sub_y = r_sub_y;
        w_list  = 1'b1;
      end else if (r_sub_x + SubStep < r_pu.w) begin
        w_sub_x = r_sub_x + SubStep;
        w_sub_y = r_sub_y;
      end else if (r_sub_y + SubStep < r_pu.h) begin
        w_sub_y = r_sub_y + SubStep;
      end else begin
        w_done = 1'b1;
      end
    end
    w_last = (w_sub_x + SubStep >= w_src.w) && (w_sub_y + SubStep >= w_src.h) &&
             (w_list || !w_src.pred_flag[1]);
    w_sub_w = sub_dim(w_src.w, w_sub_x);
    w_sub_h = sub_dim(w_src.h, w_sub_y);
    w_mv_x  = w_list ? w_src.mv1_x : w_src.mv_x;
    w_mv_y  = w_list ? w_src.mv1_y : w_src.mv_y;
    w_ref   = w_list ? w_src.ref_idx1 : w_src.ref_idx;
    w_load  = (r_state == IDLE) ? (pu_valid && (w_src.pred_flag != 2'b00)) :
                                  (cache_idle_out && !w_done);
  end

  inter_ref_coord_calc u_calc (
    .i_pu_x  (w_src.x),
    .i_pu_y  (w_src.y),
    .i_sub_x (w_sub_x),
    .i_sub_y (w_sub_y),
    .i_sub_w (w_sub_w),
    .i_sub_h (w_sub_h),
    .i_mv_x  (w_mv_x),
    .i_mv_y  (w_mv_y),
    .o_req   (w_calc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pu    <= '0;
      r_sub_x <= '0;
      r_sub_y <= '0;
      r_list  <= 1'b0;
      r_valid <= 1'b0;
      r_req   <= '0;
      r_ref   <= '0;
      r_last  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (pu_valid) begin
            r_pu <= w_in_pu;
            if (w_load) r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (cache_idle_out && w_done) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_load) begin
        r_sub_x <= w_sub_x;
        r_sub_y <= w_sub_y;
        r_list  <= w_list;
        r_valid <= 1'b1;
        r_req   <= w_calc;
        r_ref   <= w_ref;
        r_last  <= w_last;
      end
    end
  end

  assign pu_ready             = reset && (r_state == IDLE);
  assign valid_in             = r_valid;
  assign ref_idx_in_in        = r_ref;
  assign luma_ref_start_x_in  = r_req.luma_x;
  assign luma_ref_start_y_in  = r_req.luma_y;
  assign luma_ref_width_x_in  = r_req.luma_w;
  assign luma_ref_height_y_in = r_req.luma_h;
  assign chma_ref_start_x_in  = r_req.chma_x;
  assign chma_ref_start_y_in  = r_req.chma_y;
  assign chma_ref_width_x_in  = r_req.chma_w;
  assign chma_ref_height_y_in = r_req.chma_h;
  assign ch_frac_x            = r_req.frac_x;
  assign ch_frac_y            = r_req.frac_y;
  assign req_last             = r_last;
`ifdef REQ_GEN_BIPRED_EN
  assign req_list             = r_list;
`endif

  // PU sizes outside 4..64 or not a multiple of 4 are undefined.
  a_pu_dim: assert property (@(posedge clk) disable iff (!reset)
    (pu_valid && pu_ready) |-> ((pu_w[1:0] == 2'b00) && (pu_w >= 4) && (pu_w <= 64) &&
                                (pu_h[1:0] == 2'b00) && (pu_h >= 4) && (pu_h <= 64)));

endmodule

// File: tb/tb_inter_ref_req_gen.sv
// Directed self-checking bench for inter_ref_req_gen; bi-prediction steps are
// compiled in when REQ_GEN_BIPRED_EN is defined.
module tb_inter_ref_req_gen;
  import inter_req_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        pu_valid;
  logic                        pu_ready;
  logic [PIC_COORD_W-1:0]      pu_x, pu_y;
  logic [PU_DIM_W-1:0]         pu_w, pu_h;
  logic signed [MVD_WIDTH-1:0] mv_x, mv_y;
  logic [REF_ADDR_WDTH-1:0]    ref_idx;
`ifdef REQ_GEN_BIPRED_EN
  logic signed [MVD_WIDTH-1:0] mv1_x, mv1_y;
  logic [REF_ADDR_WDTH-1:0]    ref_idx1;
  logic [1:0]                  pred_flag;
  logic                        req_list;
`endif
  logic                        valid_in;
  logic                        cache_idle_out;
  logic [REF_ADDR_WDTH-1:0]    ref_idx_in_in;
  logic signed [MV_INT_W-1:0]  lx, ly, cx, cy;
  logic [LUMA_DIM_WDTH-1:0]    lw, lh, cw, ch;
  logic [MV_C_FRAC_W-1:0]      fx, fy;
  logic                        req_last;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  always #5 clk = ~clk;

  inter_ref_req_gen dut (
    .clk                  (clk),
    .reset                (reset),
    .pu_valid             (pu_valid),
    .pu_ready             (pu_ready),
    .pu_x                 (pu_x),
    .pu_y                 (pu_y),
    .pu_w                 (pu_w),
    .pu_h                 (pu_h),
    .mv_x                 (mv_x),
    .mv_y                 (mv_y),
    .ref_idx              (ref_idx),
`ifdef REQ_GEN_BIPRED_EN
    .mv1_x                (mv1_x),
    .mv1_y                (mv1_y),
    .ref_idx1             (ref_idx1),
    .pred_flag            (pred_flag),
    .req_list             (req_list),
`endif
    .valid_in             (valid_in),
    .cache_idle_out       (cache_idle_out),
    .ref_idx_in_in        (ref_idx_in_in),
    .luma_ref_start_x_in  (lx),
    .luma_ref_start_y_in  (ly),
    .luma_ref_width_x_in  (lw),
    .luma_ref_height_y_in (lh),
    .chma_ref_start_x_in  (cx),
    .chma_ref_start_y_in  (cy),
    .chma_ref_width_x_in  (cw),
    .chma_ref_height_y_in (ch),
    .ch_frac_x            (fx),
    .ch_frac_y            (fy),
    .req_last             (req_last)
  );

  always @(posedge clk) if (reset && valid_in && cache_idle_out) xfers++;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_req(input string tag, input int elx, input int ely, input int elw,
                           input int elh, input int ecx, input int ecy, input int ecw,
                           input int ech, input int efx, input int efy, input int elast);
    check({tag, ".valid"}, 32'(valid_in), 1);
    check({tag, ".lx"}, lx, elx);
    check({tag, ".ly"}, ly, ely);
    check({tag, ".lw"}, 32'(lw), elw);
    check({tag, ".lh"}, 32'(lh), elh);
    check({tag, ".cx"}, cx, ecx);
    check({tag, ".cy"}, cy, ecy);
    check({tag, ".cw"}, 32'(cw), ecw);
    check({tag, ".ch"}, 32'(ch), ech);
    check({tag, ".fx"}, 32'(fx), efx);
    check({tag, ".fy"}, 32'(fy), efy);
    check({tag, ".last"}, 32'(req_last), elast);
  endtask

  // Drive one PU at a negedge; on return the first request is visible.
  task automatic send_pu(input int x, input int y, input int w, input int h,
                         input int mx, input int my, input int r);
    pu_x = PIC_COORD_W'(x);
    pu_y = PIC_COORD_W'(y);
    pu_w = PU_DIM_W'(w);
    pu_h = PU_DIM_W'(h);
    mv_x = MVD_WIDTH'(mx);
    mv_y = MVD_WIDTH'(my);
    ref_idx  = REF_ADDR_WDTH'(r);
    pu_valid = 1'b1;
    @(negedge clk);
    pu_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    reset = 1'b0; pu_valid = 1'b0; cache_idle_out = 1'b1;
    pu_x = '0; pu_y = '0; pu_w = 7'd8; pu_h = 7'd8; mv_x = '0; mv_y = '0; ref_idx = '0;
`ifdef REQ_GEN_BIPRED_EN
    mv1_x = '0; mv1_y = '0; ref_idx1 = '0; pred_flag = 2'b01;
`endif
    repeat (3) @(negedge clk);
    check("rst.valid", 32'(valid_in), 0);
    check("rst.ready", 32'(pu_ready), 0);
    check("rst.lx", lx, 0);
    check("rst.last", 32'(req_last), 0);
    reset = 1'b1;
    #1 check("rst.ready_after", 32'(pu_ready), 1);
    @(negedge clk);

    // 1: single 8x8 request
    send_pu(16, 8, 8, 8, 0, 0, 0);
    check_req("t1", 13, 5, 15, 15, 7, 3, 7, 7, 0, 0, 1);
    check("t1.busy", 32'(pu_ready), 0);
    @(negedge clk);
    check("t1.done", 32'(valid_in), 0);
    check("t1.ready", 32'(pu_ready), 1);

    // 2: negative MV, two sub-blocks
    send_pu(0, 0, 16, 8, -5, 6, 0);
    check_req("t2a", -5, -2, 15, 15, -2, -1, 7, 7, 3, 6, 0);
    @(negedge clk);
    check_req("t2b", 3, -2, 15, 15, 2, -1, 7, 7, 3, 6, 1);
    @(negedge clk);
    check("t2.done", 32'(valid_in), 0);

    // 3: backpressure holds the request stable, one transfer
    cache_idle_out = 1'b0;
    x0 = xfers;
    send_pu(16, 8, 8, 8, 0, 0, 5);
    for (int i = 0; i < 6; i++) begin
      check("t3.valid", 32'(valid_in), 1);
      check("t3.lx", lx, 13);
      check("t3.ref", 32'(ref_idx_in_in), 5);
      if (i < 5) @(negedge clk);
    end
    cache_idle_out = 1'b1;
    @(negedge clk);
    check("t3.done", 32'(valid_in), 0);
    check("t3.xfers", xfers - x0, 1);

    // 4: partial sub-block widths
    send_pu(0, 0, 12, 4, 0, 0, 0);
    check_req("t4a", -3, -3, 15, 11, -1, -1, 7, 5, 0, 0, 0);
    @(negedge clk);
    check_req("t4b", 5, -3, 11, 11, 3, -1, 5, 5, 0, 0, 1);
    @(negedge clk);
    check("t4.done", 32'(valid_in), 0);

    // 5: reset in the middle of a 64x64 PU
    send_pu(0, 0, 64, 64, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("t5.lx4", lx, 21);
    check("t5.last4", 32'(req_last), 0);
    reset = 1'b0;
    @(negedge clk);
    check("t5.valid", 32'(valid_in), 0);
    check("t5.lx", lx, 0);
    check("t5.lw", 32'(lw), 0);
    check("t5.cw", 32'(cw), 0);
    check("t5.ready", 32'(pu_ready), 0);
    reset = 1'b1;
    @(negedge clk);
    check("t5.idle", 32'(valid_in), 0);
    check("t5.ready_after", 32'(pu_ready), 1);
    send_pu(16, 8, 8, 8, 0, 0, 0);
    check_req("t5n", 13, 5, 15, 15, 7, 3, 7, 7, 0, 0, 1);
    @(negedge clk);
    check("t5n.done", 32'(valid_in), 0);

`ifdef REQ_GEN_BIPRED_EN
    // 6: bi-prediction, L0 then L1 per sub-block
    mv1_x = 16'sd8; mv1_y = 16'sd4; ref_idx1 = 4'd7; pred_flag = 2'b11;
    send_pu(0, 0, 16, 8, 0, 0, 2);
    check_req("t6a", -3, -3, 15, 15, -1, -1, 7, 7, 0, 0, 0);
    check("t6a.list", 32'(req_list), 0);
    check("t6a.ref", 32'(ref_idx_in_in), 2);
    @(negedge clk);
    check_req("t6b", -1, -2, 15, 15, 0, -1, 7, 7, 0, 4, 0);
    check("t6b.list", 32'(req_list), 1);
    check("t6b.ref", 32'(ref_idx_in_in), 7);
    @(negedge clk);
    check_req("t6c", 5, -3, 15, 15, 3, -1, 7, 7, 0, 0, 0);
    check("t6c.list", 32'(req_list), 0);
    @(negedge clk);
    check_req("t6d", 7, -2, 15, 15, 4, -1, 7, 7, 0, 4, 1);
    check("t6d.list", 32'(req_list), 1);
    check("t6d.ref", 32'(ref_idx_in_in), 7);
    @(negedge clk);
    check("t6.done", 32'(valid_in), 0);
    pred_flag = 2'b00;
    send_pu(0, 0, 8, 8, 0, 0, 0);
    check("t6z.valid", 32'(valid_in), 0);
    check("t6z.ready", 32'(pu_ready), 1);
    pred_flag = 2'b01;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
